// File: rtl/boot_mem_ctrl.sv
// Boot memory controller: streams a boot image into RAM while holding
// the CPU in reset, then serves CPU bus reads/writes and one IO register.
module boot_mem_ctrl #(
    parameter int                   WORD_SIZE = 16,
    parameter int                   MEM_DEPTH = 256,
    parameter logic [WORD_SIZE-1:0] IO_ADDR   = 16'hFF00
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WORD_SIZE-1:0] addr_bus,
    inout  wire  [7:0]           data_bus,
    input  logic                 read_en,
    input  logic                 write_en,
    input  logic                 load_valid,
    input  logic [7:0]           load_data,
    input  logic                 load_last,
    output logic                 load_ready,
    output logic                 cpu_reset,
    output logic                 boot_done,
    output logic [7:0]           io_out,
    output logic                 bus_err
);

    localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [WORD_SIZE-1:0] DEPTH_A = WORD_SIZE'(MEM_DEPTH);
    localparam logic [AW-1:0] LAST_PTR = AW'(MEM_DEPTH - 1);

    typedef enum logic {
        S_LOAD,
        S_RUN
    } state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] load_ptr_q, load_ptr_d;
    logic          load_ready_q, load_ready_d;
    logic          rd_valid_q, rd_valid_d;
    logic [7:0]    rd_data_q, rd_data_d;
    logic [7:0]    io_out_q, io_out_d;
    logic          bus_err_q, bus_err_d;

    logic [7:0]    mem_q [MEM_DEPTH];
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [7:0]    mem_wdata;

    logic          in_ram;
    logic          is_io;

    assign in_ram = (addr_bus < DEPTH_A);
    assign is_io  = (addr_bus == IO_ADDR);

    always_comb begin
        state_d    = state_q;
        load_ptr_d = load_ptr_q;
        rd_valid_d = 1'b0;
        rd_data_d  = rd_data_q;
        io_out_d   = io_out_q;
        bus_err_d  = bus_err_q;
        mem_we     = 1'b0;
        mem_waddr  = load_ptr_q;
        mem_wdata  = load_data;

        unique case (state_q)
            S_LOAD: begin
                if (load_valid && load_ready_q) begin
                    mem_we = 1'b1;
                    if (load_last || (load_ptr_q == LAST_PTR)) begin
                        state_d = S_RUN;
                    end else begin
                        load_ptr_d = load_ptr_q + 1'b1;
                    end
                end
            end
            S_RUN: begin
                // Conflicting strobes: release the bus, drop the write.
                if (read_en && write_en) begin
                    bus_err_d = 1'b1;
                end else if (write_en) begin
                    if (in_ram) begin
                        mem_we    = 1'b1;
                        mem_waddr = addr_bus[AW-1:0];
                        mem_wdata = data_bus;
                    end else if (is_io) begin
                        io_out_d = data_bus;
                    end
                end else if (read_en) begin
                    rd_valid_d = 1'b1;
                    if (in_ram) begin
                        rd_data_d = mem_q[addr_bus[AW-1:0]];
                    end else if (is_io) begin
                        rd_data_d = io_out_q;
                    end else begin
                        rd_data_d = 8'hFF;
                    end
                end
            end
            default: begin
                state_d = S_LOAD;
            end
        endcase

        load_ready_d = (state_d == S_LOAD);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_LOAD;
            load_ptr_q   <= '0;
            load_ready_q <= 1'b0;
            rd_valid_q   <= 1'b0;
            rd_data_q    <= 8'h00;
            io_out_q     <= 8'h00;
            bus_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            load_ptr_q   <= load_ptr_d;
            load_ready_q <= load_ready_d;
            rd_valid_q   <= rd_valid_d;
            rd_data_q    <= rd_data_d;
            io_out_q     <= io_out_d;
            bus_err_q    <= bus_err_d;
        end
    end

    // RAM survives reset so a partial reload keeps the old image.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    assign data_bus   = rd_valid_q ? rd_data_q : {8{1'bz}};
    assign load_ready = load_ready_q;
    assign cpu_reset  = (state_q == S_RUN);
    assign boot_done  = (state_q == S_RUN);
    assign io_out     = io_out_q;
    assign bus_err    = bus_err_q;

endmodule

// File: tb/tb_boot_mem_ctrl.sv
// Self-checking bench for boot_mem_ctrl: table vectors, corner sequences
// and randomized bus traffic against a transaction-level memory model.
module tb_boot_mem_ctrl;

    localparam int          DEPTH = 32;
    localparam logic [15:0] IOA   = 16'hFF00;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] addr_bus;
    wire  [7:0]  data_bus;
    logic        read_en;
    logic        write_en;
    logic        load_valid;
    logic [7:0]  load_data;
    logic        load_last;
    logic        load_ready;
    logic        cpu_reset;
    logic        boot_done;
    logic [7:0]  io_out;
    logic        bus_err;

    logic [7:0]  tb_d;
    logic        tb_oe;

    assign data_bus = tb_oe ? tb_d : {8{1'bz}};
    pullup (data_bus);

    always #5 clk = ~clk;

    boot_mem_ctrl #(
        .WORD_SIZE(16),
        .MEM_DEPTH(DEPTH),
        .IO_ADDR  (IOA)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .addr_bus  (addr_bus),
        .data_bus  (data_bus),
        .read_en   (read_en),
        .write_en  (write_en),
        .load_valid(load_valid),
        .load_data (load_data),
        .load_last (load_last),
        .load_ready(load_ready),
        .cpu_reset (cpu_reset),
        .boot_done (boot_done),
        .io_out    (io_out),
        .bus_err   (bus_err)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] ref_mem [DEPTH];
    logic [7:0] ref_io;
    logic       ref_err;
    logic       ref_run;
    int         ref_ptr;

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [7:0]  data;
    } vec_t;

    vec_t tbl[14];

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [7:0] ref_read(input logic [15:0] a);
        if (int'(a) < DEPTH) return ref_mem[a[4:0]];
        if (a == IOA) return ref_io;
        return 8'hFF;
    endfunction

    task automatic model_reset();
        ref_run = 1'b0;
        ref_ptr = 0;
        ref_io  = 8'h00;
        ref_err = 1'b0;
    endtask

    task automatic load_cycle(input logic v, input logic [7:0] d,
                              input logic last);
        load_valid = v;
        load_data  = d;
        load_last  = last;
        @(negedge clk);
        if (v && !ref_run) begin
            ref_mem[ref_ptr] = d;
            if (last || ref_ptr == DEPTH - 1) ref_run = 1'b1;
            else ref_ptr++;
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
        chk("load_ready", load_ready, !ref_run);
        chk("cpu_reset", cpu_reset, ref_run);
        chk("boot_done", boot_done, ref_run);
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
        addr_bus = a;
        write_en = 1'b1;
        tb_d     = d;
        tb_oe    = 1'b1;
        @(negedge clk);
        write_en = 1'b0;
        tb_oe    = 1'b0;
        if (int'(a) < DEPTH) ref_mem[a[4:0]] = d;
        else if (a == IOA) ref_io = d;
        chk("io_out", io_out, ref_io);
        chk("bus_err", bus_err, ref_err);
    endtask

    task automatic bus_read(input logic [15:0] a, output logic [7:0] d,
                            output logic [7:0] hz);
        addr_bus = a;
        read_en  = 1'b1;
        @(negedge clk);
        d       = data_bus;
        read_en = 1'b0;
        @(negedge clk);
        hz = data_bus;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0]  d, hz, d0, d1, d2, first_b, last_b;
        logic [15:0] a;

        reset      = 1'b0;
        addr_bus   = '0;
        read_en    = 1'b0;
        write_en   = 1'b0;
        load_valid = 1'b0;
        load_data  = '0;
        load_last  = 1'b0;
        tb_d       = '0;
        tb_oe      = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);

        chk("rst_load_ready", load_ready, 0);
        chk("rst_cpu_reset", cpu_reset, 0);
        chk("rst_boot_done", boot_done, 0);
        chk("rst_io_out", io_out, 0);
        chk("rst_bus_err", bus_err, 0);
        chk("rst_bus_hiz", data_bus, 8'hFF);

        reset = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", load_ready, 1);

        load_cycle(1'b1, 8'h11, 1'b0);
        load_cycle(1'b1, 8'h22, 1'b0);
        load_cycle(1'b1, 8'h33, 1'b1);
        chk("boot_ready_low", load_ready, 0);

        bus_read(16'h0000, d, hz);
        chk("boot_rd0", d, 8'h11);
        bus_read(16'h0001, d, hz);
        chk("boot_rd1", d, 8'h22);
        bus_read(16'h0002, d, hz);
        chk("boot_rd2", d, 8'h33);

        tbl[0]  = '{1'b1, 16'h0010, 8'hA5};
        tbl[1]  = '{1'b0, 16'h0010, 8'hA5};
        tbl[2]  = '{1'b1, 16'hFF00, 8'h5A};
        tbl[3]  = '{1'b0, 16'hFF00, 8'h5A};
        tbl[4]  = '{1'b0, 16'h1234, 8'hFF};
        tbl[5]  = '{1'b1, 16'h1234, 8'h77};
        tbl[6]  = '{1'b0, 16'h1234, 8'hFF};
        tbl[7]  = '{1'b0, 16'h0010, 8'hA5};
        tbl[8]  = '{1'b1, 16'h001F, 8'h3C};
        tbl[9]  = '{1'b0, 16'h001F, 8'h3C};
        tbl[10] = '{1'b0, 16'h0020, 8'hFF};
        tbl[11] = '{1'b1, 16'h0020, 8'h99};
        tbl[12] = '{1'b0, 16'h0000, 8'h11};
        tbl[13] = '{1'b0, 16'hFF00, 8'h5A};

        for (int i = 0; i < 14; i++) begin
            if (tbl[i].wr) begin
                bus_write(tbl[i].addr, tbl[i].data);
            end else begin
                bus_read(tbl[i].addr, d, hz);
                chk($sformatf("tbl_rd%0d", i), d, tbl[i].data);
                if (tbl[i].data != 8'hFF) chk($sformatf("tbl_hiz%0d", i), hz, 8'hFF);
            end
        end

        for (int i = 0; i < DEPTH; i++) begin
            bus_write(16'(i), 8'($urandom_range(0, 255)));
        end

        addr_bus = 16'h0003;
        read_en  = 1'b1;
        @(negedge clk);
        d0       = data_bus;
        addr_bus = 16'hFF00;
        @(negedge clk);
        d1       = data_bus;
        addr_bus = 16'h0007;
        @(negedge clk);
        d2       = data_bus;
        read_en  = 1'b0;
        @(negedge clk);
        chk("b2b_0", d0, ref_read(16'h0003));
        chk("b2b_1", d1, ref_read(16'hFF00));
        chk("b2b_2", d2, ref_read(16'h0007));

        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 6))
                5: a = IOA;
                6: a = 16'($urandom_range(DEPTH, 16'hFEFF));
                default: a = 16'($urandom_range(0, DEPTH - 1));
            endcase
            if ($urandom_range(0, 1) == 1) begin
                bus_write(a, 8'($urandom_range(0, 255)));
            end else begin
                bus_read(a, d, hz);
                chk($sformatf("rand_rd@%0h", a), d, ref_read(a));
            end
        end

        bus_write(16'h0005, 8'h42);
        addr_bus = 16'h0005;
        read_en  = 1'b1;
        write_en = 1'b1;
        tb_d     = 8'hEE;
        tb_oe    = 1'b1;
        @(negedge clk);
        read_en  = 1'b0;
        write_en = 1'b0;
        tb_oe    = 1'b0;
        ref_err  = 1'b1;
        #1;
        chk("conflict_hiz", data_bus, 8'hFF);
        chk("conflict_err", bus_err, 1);
        repeat (3) @(negedge clk);
        bus_read(16'h0005, d, hz);
        chk("conflict_mem", d, 8'h42);
        chk("err_sticky", bus_err, 1);

        bus_write(16'h0010, 8'hA5);
        addr_bus = 16'h0010;
        read_en  = 1'b1;
        @(negedge clk);
        chk("run_rd_active", data_bus, 8'hA5);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_hiz", data_bus, 8'hFF);
        chk("mid_rst_cpu", cpu_reset, 0);
        chk("mid_rst_ready", load_ready, 0);
        chk("mid_rst_done", boot_done, 0);
        chk("mid_rst_err", bus_err, 0);
        chk("mid_rst_io", io_out, 0);
        model_reset();
        read_en = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("reload_ready", load_ready, 1);

        load_cycle(1'b0, 8'h00, 1'b0);
        load_cycle(1'b1, 8'hC0, 1'b0);
        load_cycle(1'b0, 8'hBB, 1'b1);
        load_cycle(1'b0, 8'hBB, 1'b0);
        load_cycle(1'b1, 8'hC1, 1'b1);
        for (int i = 0; i < DEPTH; i++) begin
            bus_read(16'(i), d, hz);
            chk($sformatf("reload_rd%0d", i), d, ref_read(16'(i)));
        end

        #3 reset = 1'b0;
        #2;
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        first_b = 8'($urandom_range(0, 127));
        last_b  = 8'($urandom_range(128, 255));
        for (int i = 0; i < DEPTH; i++) begin
            if ($urandom_range(0, 2) == 0) load_cycle(1'b0, 8'hAA, 1'b0);
            if (i == 0) d = first_b;
            else if (i == DEPTH - 1) d = last_b;
            else d = 8'($urandom_range(0, 255));
            load_cycle(1'b1, d, 1'b0);
        end
        chk("ovf_run", boot_done, 1);
        load_cycle(1'b1, 8'hDE, 1'b0);
        bus_read(16'h0000, d, hz);
        chk("ovf_mem0", d, first_b);
        bus_read(16'(DEPTH - 1), d, hz);
        chk("ovf_memlast", d, last_b);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/boot_mem_ctrl.md
Name: boot_mem_ctrl

Overview:
- Memory and bus slave on the CPU external bus: address bus, 8-bit bidirectional data bus, read/write strobes.
- Holds a byte-wide RAM plus one memory-mapped output register.
- After reset, a boot loader fills the RAM from a streaming load port while it holds the CPU in reset.
- Once loading completes, it releases the CPU and serves its bus reads and writes.

Parameters:
- WORD_SIZE, 16: address bus width.
- MEM_DEPTH, 256: RAM size in bytes; RAM maps to addresses 0 .. MEM_DEPTH-1. Requires MEM_DEPTH <= IO_ADDR and MEM_DEPTH >= 2.
- IO_ADDR, 16'hFF00: address of the io_out register.

Ports:
- clk, input, 1: system clock; all state updates on its rising edge.
- reset, input, 1: asynchronous, active-low reset.
- addr_bus, input, WORD_SIZE: CPU address.
- data_bus, inout, 8: CPU data bus. This block drives it only during the read-data window; otherwise high-Z.
- read_en, input, 1: CPU read strobe, active-high.
- write_en, input, 1: CPU write strobe, active-high.
- load_valid, input, 1: load byte valid.
- load_data, input, 8: load byte.
- load_last, input, 1: marks the final load byte; qualified by load_valid.
- load_ready, output, 1: loader accepts a byte this cycle.
- cpu_reset, output, 1: active-low reset to the CPU; low while booting.
- boot_done, output, 1: high in RUN state.
- io_out, output, 8: memory-mapped output register.
- bus_err, output, 1: sticky error flag for illegal bus cycles.

Behaviour:
- Reset (reset low, asynchronous) forces:
  - state = LOAD, load_ptr = 0, io_out = 0, bus_err = 0.
  - rd_valid = 0, so data_bus is high-Z.
  - load_ready = 0, cpu_reset = 0, boot_done = 0.
  - RAM contents are not cleared.
- State LOAD:
  - load_ready = 1 from the first clock edge after reset deasserts.
  - Bus strobes are ignored and data_bus is never driven.
  - Transfer occurs when load_valid && load_ready: mem[load_ptr] <= load_data, then load_ptr increments.
  - Transfer with load_last = 1, or transfer at load_ptr = MEM_DEPTH-1: the byte is written and the state moves to RUN on the same edge. No wrap; excess bytes are never accepted.
  - load_valid = 0 holds the state and pointer.
- State RUN:
  - load_ready = 0, cpu_reset = 1, boot_done = 1.
  - RUN is left only via reset.
- Read (RUN, read_en = 1, write_en = 0, sampled at edge N):
  - rd_data is registered at edge N.
  - data_bus is driven with rd_data from after edge N until the edge after read_en is sampled low. Latency is one cycle.
  - Decode: addr < MEM_DEPTH returns mem[addr]; addr == IO_ADDR returns io_out; any other address returns 8'hFF.
  - Back-to-back reads (read_en held) return a new byte each cycle for the address sampled on the previous edge.
- Write (RUN, write_en = 1, read_en = 0, sampled at edge N):
  - data_bus is sampled at edge N.
  - addr < MEM_DEPTH writes mem[addr]; addr == IO_ADDR writes io_out; other addresses are dropped silently.
  - A read issued on the next cycle to the same address returns the new value.
- Simultaneous read_en = 1 and write_en = 1 in RUN:
  - No write occurs and rd_valid clears (bus released).
  - bus_err is set and stays set until reset.
- Turnaround: rd_valid clears on any edge where read_en = 0 or write_en = 1, so the CPU can drive data_bus in the next cycle.
- Reset asserted mid-RUN: everything returns to LOAD immediately (asynchronously), including cpu_reset = 0 and the bus released. RAM retains its contents, so a zero-length reload is not possible; at least one load byte is required.

Test Plan:
- Boot: release reset, stream 0x11, 0x22, 0x33 with load_last on 0x33, one byte per cycle. Expect:
  - load_ready = 1, then 0 after the third transfer.
  - cpu_reset and boot_done go 1 on the same edge.
  - Bus reads of addresses 0, 1, 2 return 0x11, 0x22, 0x33 one cycle after read_en.
- Load stall and overflow with MEM_DEPTH = 4:
  - Insert load_valid gaps; expect the pointer to hold.
  - Send 5 bytes with no load_last; expect RUN after the 4th, the 5th not accepted, and mem[0] unchanged by it.
- Write then read: write 0xA5 to addr 0x0010, then read 0x0010 on the next cycle. Expect 0xA5 on data_bus one cycle later, then high-Z one cycle after read_en drops.
- IO and unmapped: write 0x5A to 0xFF00, expect io_out = 0x5A on the next cycle. Read 0xFF00, expect 0x5A. Read 0x1234, expect 0xFF. Write 0x1234, expect no state change.
- Strobe conflict: in RUN, assert read_en = write_en = 1 at addr 5. Expect mem[5] unchanged, data_bus high-Z, bus_err = 1 held until reset.
- Reset mid-run: in RUN during an active read, assert reset. Expect data_bus high-Z, cpu_reset = 0 and load_ready = 0 immediately. After reload, addresses not reloaded keep their old values.
